// File: rtl/motor_cmd_sequencer.sv
// Purpose : open/close motor sequencer driven by UART command bytes, with end-stops, dead-time and travel timeout.
// Latency : registered outputs; a command or synchronised limit changes motor/busy/fault/TxValid one clock later.
// Backpressure: none on RxDone; a status byte waits on TxValid until TxDone, newer reports overwrite (last wins).
//
// Ports:
//   Clk, Rst_n            single clock, asynchronous active-low reset
//   RxData, RxDone        received command byte, qualified by a one-cycle RxDone pulse
//   finalcarrera1/2       open / closed end-stops (asynchronous, synchronised internally)
//   TxDone                one-cycle pulse: TX finished sending TxData
//   motor1, motor2        drive open / drive close (never both high)
//   busy, fault           in a dead-time or travelling state / in the fault state
//   TxData, TxValid       pending status byte ('O','K','S','F')
//
// Optional feature: define STATUS_REPORT_EN to build the status-report path.
// Without it TxData/TxValid are tied low and TxDone is ignored; the FSM is identical.

module motor_cmd_sequencer #(
  parameter int unsigned DEADTIME_CYC = 50000,
  parameter int unsigned TIMEOUT_CYC  = 500000000,
  parameter logic [7:0]  CMD_OPEN     = 8'h41,
  parameter logic [7:0]  CMD_CLOSE    = 8'h43,
  parameter logic [7:0]  CMD_STOP     = 8'h53
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] RxData,
  input  logic       RxDone,
  input  logic       finalcarrera1,
  input  logic       finalcarrera2,
  input  logic       TxDone,
  output logic       motor1,
  output logic       motor2,
  output logic       busy,
  output logic       fault,
  output logic [7:0] TxData,
  output logic       TxValid
);

  localparam logic [31:0] DEAD_LAST = 32'(DEADTIME_CYC - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);

  localparam logic [7:0] RPT_OPEN   = 8'h4F;  // 'O' reached open end
  localparam logic [7:0] RPT_CLOSED = 8'h4B;  // 'K' reached closed end
  localparam logic [7:0] RPT_STOP   = 8'h53;  // 'S' stopped / fault cleared
  localparam logic [7:0] RPT_FAULT  = 8'h46;  // 'F' fault

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAD_OPEN,
    ST_OPENING,
    ST_DEAD_CLOSE,
    ST_CLOSING,
    ST_FAULT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] dead_cnt, tmo_cnt;
  logic        dead_clr, dead_inc, tmo_clr, tmo_inc;
  logic        rpt_vld;
  logic [7:0]  rpt_byte;

  // Two-flop synchronisers for the end-stops; all decisions use lim_o/lim_c.
  logic lim_o_meta, lim_o, lim_c_meta, lim_c;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lim_o_meta <= 1'b0;
      lim_o      <= 1'b0;
      lim_c_meta <= 1'b0;
      lim_c      <= 1'b0;
    end else begin
      lim_o_meta <= finalcarrera1;
      lim_o      <= lim_o_meta;
      lim_c_meta <= finalcarrera2;
      lim_c      <= lim_c_meta;
    end
  end

  logic cmd_open, cmd_close, cmd_stop;
  assign cmd_open  = RxDone && (RxData == CMD_OPEN);
  assign cmd_close = RxDone && (RxData == CMD_CLOSE);
  assign cmd_stop  = RxDone && (RxData == CMD_STOP);

  // Branch order inside each state encodes the per-cycle priority:
  // both limits, reached limit, timeout, then command. A losing command is dropped.
  always_comb begin
    state_nx = state;
    dead_clr = 1'b0;
    dead_inc = 1'b0;
    tmo_clr  = 1'b0;
    tmo_inc  = 1'b0;
    rpt_vld  = 1'b0;
    rpt_byte = 8'h00;

    if (lim_o && lim_c) begin
      state_nx = ST_FAULT;
      // Report only on entry so a held double-limit does not spam the TX path.
      if (state != ST_FAULT) begin
        rpt_vld  = 1'b1;
        rpt_byte = RPT_FAULT;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_open) begin
            if (lim_o) begin
              rpt_vld  = 1'b1;
              rpt_byte = RPT_OPEN;
            end else begin
              state_nx = ST_DEAD_OPEN;
              dead_clr = 1'b1;
            end
          end else if (cmd_close) begin
            if (lim_c) begin
              rpt_vld  = 1'b1;
              rpt_byte = RPT_CLOSED;
            end else begin
              state_nx = ST_DEAD_CLOSE;
              dead_clr = 1'b1;
            end
          end else if (cmd_stop) begin
            rpt_vld  = 1'b1;
            rpt_byte = RPT_STOP;
          end
        end

        ST_DEAD_OPEN: begin
          if (cmd_stop) begin
            state_nx = ST_IDLE;
            rpt_vld  = 1'b1;
            rpt_byte = RPT_STOP;
          end else if (cmd_close) begin
            state_nx = ST_DEAD_CLOSE;
            dead_clr = 1'b1;
          end else if (dead_cnt == DEAD_LAST) begin
            state_nx = ST_OPENING;
            tmo_clr  = 1'b1;
          end else begin
            dead_inc = 1'b1;
          end
        end

        ST_DEAD_CLOSE: begin
          if (cmd_stop) begin
            state_nx = ST_IDLE;
            rpt_vld  = 1'b1;
            rpt_byte = RPT_STOP;
          end else if (cmd_open) begin
            state_nx = ST_DEAD_OPEN;
            dead_clr = 1'b1;
          end else if (dead_cnt == DEAD_LAST) begin
            state_nx = ST_CLOSING;
            tmo_clr  = 1'b1;
          end else begin
            dead_inc = 1'b1;
          end
        end

        ST_OPENING: begin
          if (lim_o) begin
            state_nx = ST_IDLE;
            rpt_vld  = 1'b1;
            rpt_byte = RPT_OPEN;
          end else if (tmo_cnt == TMO_LAST) begin
            state_nx = ST_FAULT;
            rpt_vld  = 1'b1;
            rpt_byte = RPT_FAULT;
          end else if (cmd_stop) begin
            state_nx = ST_IDLE;
            rpt_vld  = 1'b1;
            rpt_byte = RPT_STOP;
          end else if (cmd_close) begin
            // Reversal always goes through a fresh dead-time.
            state_nx = ST_DEAD_CLOSE;
            dead_clr = 1'b1;
          end else begin
            tmo_inc = 1'b1;
          end
        end

        ST_CLOSING: begin
          if (lim_c) begin
            state_nx = ST_IDLE;
            rpt_vld  = 1'b1;
            rpt_byte = RPT_CLOSED;
          end else if (tmo_cnt == TMO_LAST) begin
            state_nx = ST_FAULT;
            rpt_vld  = 1'b1;
            rpt_byte = RPT_FAULT;
          end else if (cmd_stop) begin
            state_nx = ST_IDLE;
            rpt_vld  = 1'b1;
            rpt_byte = RPT_STOP;
          end else if (cmd_open) begin
            state_nx = ST_DEAD_OPEN;
            dead_clr = 1'b1;
          end else begin
            tmo_inc = 1'b1;
          end
        end

        ST_FAULT: begin
          // The double-limit case was handled above, so STOP here is always legal.
          if (cmd_stop) begin
            state_nx = ST_IDLE;
            rpt_vld  = 1'b1;
            rpt_byte = RPT_STOP;
          end
        end

        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dead_cnt <= 32'd0;
    end else if (dead_clr) begin
      dead_cnt <= 32'd0;
    end else if (dead_inc) begin
      dead_cnt <= dead_cnt + 32'd1;
    end
  end

  // Saturating, although the timeout compare normally leaves the state first.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tmo_cnt <= 32'd0;
    end else if (tmo_clr) begin
      tmo_cnt <= 32'd0;
    end else if (tmo_inc && (tmo_cnt != 32'hFFFF_FFFF)) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  // Outputs are flops decoded from the next state, so they track the state
  // register exactly and have no combinational path from any input.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      motor1 <= 1'b0;
      motor2 <= 1'b0;
      busy   <= 1'b0;
      fault  <= 1'b0;
    end else begin
      motor1 <= (state_nx == ST_OPENING);
      motor2 <= (state_nx == ST_CLOSING);
      busy   <= (state_nx == ST_DEAD_OPEN) || (state_nx == ST_OPENING) ||
                (state_nx == ST_DEAD_CLOSE) || (state_nx == ST_CLOSING);
      fault  <= (state_nx == ST_FAULT);
    end
  end

`ifdef STATUS_REPORT_EN
  // A new report beats a simultaneous TxDone and overwrites any pending byte.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      TxData  <= 8'h00;
      TxValid <= 1'b0;
    end else if (rpt_vld) begin
      TxData  <= rpt_byte;
      TxValid <= 1'b1;
    end else if (TxDone) begin
      TxValid <= 1'b0;
    end
  end
`else
  assign TxData  = 8'h00;
  assign TxValid = 1'b0;

  logic unused_rpt;
  assign unused_rpt = ^{TxDone, rpt_vld, rpt_byte};
`endif

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_motor_cmd_sequencer;

  localparam int DEAD = 4;
  localparam int TMO  = 100;

  logic       Clk = 1'b1;
  logic       Rst_n = 1'b1;
  logic [7:0] RxData = 8'h00;
  logic       RxDone = 1'b0;
  logic       finalcarrera1 = 1'b0;
  logic       finalcarrera2 = 1'b0;
  logic       TxDone = 1'b0;
  logic       motor1, motor2, busy, fault, TxValid;
  logic [7:0] TxData;

  motor_cmd_sequencer #(
    .DEADTIME_CYC(DEAD),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .RxData       (RxData),
    .RxDone       (RxDone),
    .finalcarrera1(finalcarrera1),
    .finalcarrera2(finalcarrera2),
    .TxDone       (TxDone),
    .motor1       (motor1),
    .motor2       (motor2),
    .busy         (busy),
    .fault        (fault),
    .TxData       (TxData),
    .TxValid      (TxValid)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       m1, m2, bsy, flt, txv;
    logic [7:0] txd;
  } pl_t;

  typedef struct packed {
    logic [31:0] stamp;
    pl_t         pl;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // ---------------- reference model (behavioural) ----------------
  typedef enum {M_IDLE, M_PREP_OPEN, M_RUN_OPEN, M_PREP_CLOSE, M_RUN_CLOSE, M_FAULT} mode_e;
  mode_e mode = M_IDLE;
  int    dead_left = 0;
  int    drive_cnt = 0;
  bit    so[2];
  bit    sc[2];
  bit    tx_v = 0;
  byte   tx_d = 0;
  bit    mdl_ok = 0;
  pl_t   last_pl = 'x;
  pl_t   prior_pl = 'x;

  function automatic pl_t view();
    pl_t p;
    p.m1  = (mode == M_RUN_OPEN);
    p.m2  = (mode == M_RUN_CLOSE);
    p.bsy = (mode == M_PREP_OPEN) || (mode == M_RUN_OPEN) ||
            (mode == M_PREP_CLOSE) || (mode == M_RUN_CLOSE);
    p.flt = (mode == M_FAULT);
`ifdef STATUS_REPORT_EN
    p.txv = tx_v;
    p.txd = tx_d;
`else
    p.txv = 1'b0;
    p.txd = 8'h00;
`endif
    return p;
  endfunction

  // Record the value the outputs should show at this cycle; a later update in the
  // same cycle (async reset after a clock edge) replaces the earlier one.
  task automatic commit();
    obs_t e;
    pl_t  p;
    p = view();
    if (exp_q.size() > 0 && exp_q[$].stamp == 32'(cyc)) begin
      void'(exp_q.pop_back());
      last_pl = prior_pl;
    end
    if (p !== last_pl) begin
      prior_pl = last_pl;
      e.stamp  = 32'(cyc);
      e.pl     = p;
      exp_q.push_back(e);
      last_pl  = p;
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE; dead_left = 0; drive_cnt = 0;
    so[0] = 0; so[1] = 0; sc[0] = 0; sc[1] = 0;
    tx_v = 0; tx_d = 0;
    mdl_ok = 1;
    commit();
  endtask

  task automatic enter_prep(input mode_e m);
    mode = m;
    dead_left = DEAD;
  endtask

  task automatic model_step();
    bit  lo, lc, c_o, c_c, c_s, opening;
    byte rep;
    lo = so[1]; lc = sc[1];
    so[1] = so[0]; so[0] = finalcarrera1;
    sc[1] = sc[0]; sc[0] = finalcarrera2;
    c_o = RxDone && RxData == 8'h41;
    c_c = RxDone && RxData == 8'h43;
    c_s = RxDone && RxData == 8'h53;
    rep = 0;
    if (lo && lc) begin
      if (mode != M_FAULT) rep = 8'h46;
      mode = M_FAULT;
    end else begin
      case (mode)
        M_IDLE: begin
          if (c_o) begin
            if (lo) rep = 8'h4F; else enter_prep(M_PREP_OPEN);
          end else if (c_c) begin
            if (lc) rep = 8'h4B; else enter_prep(M_PREP_CLOSE);
          end else if (c_s) rep = 8'h53;
        end
        M_PREP_OPEN, M_PREP_CLOSE: begin
          if (c_s) begin
            mode = M_IDLE; rep = 8'h53;
          end else if (mode == M_PREP_OPEN && c_c) enter_prep(M_PREP_CLOSE);
          else if (mode == M_PREP_CLOSE && c_o) enter_prep(M_PREP_OPEN);
          else begin
            dead_left--;
            if (dead_left == 0) begin
              mode = (mode == M_PREP_OPEN) ? M_RUN_OPEN : M_RUN_CLOSE;
              drive_cnt = 0;
            end
          end
        end
        M_RUN_OPEN, M_RUN_CLOSE: begin
          opening = (mode == M_RUN_OPEN);
          drive_cnt++;
          if (opening ? lo : lc) begin
            mode = M_IDLE; rep = opening ? 8'h4F : 8'h4B;
          end else if (drive_cnt >= TMO) begin
            mode = M_FAULT; rep = 8'h46;
          end else if (c_s) begin
            mode = M_IDLE; rep = 8'h53;
          end else if (opening ? c_c : c_o) begin
            enter_prep(opening ? M_PREP_CLOSE : M_PREP_OPEN);
          end
        end
        M_FAULT: begin
          if (c_s) begin
            mode = M_IDLE; rep = 8'h53;
          end
        end
        default: mode = M_IDLE;
      endcase
    end
    if (rep != 0) begin
      tx_v = 1; tx_d = rep;
    end else if (TxDone) begin
      tx_v = 0;
    end
  endtask

  always @(negedge Rst_n) model_reset();

  always @(posedge Clk) begin
    cyc++;
    if (Rst_n && mdl_ok) begin
      model_step();
      commit();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  function automatic string fmt(input obs_t o);
    return $sformatf("cyc=%0d m1=%b m2=%b busy=%b fault=%b TxValid=%b TxData=%h",
                     o.stamp, o.pl.m1, o.pl.m2, o.pl.bsy, o.pl.flt, o.pl.txv, o.pl.txd);
  endfunction

  initial begin
    obs_t cur, e;
    pl_t  seen;
    seen = 'x;
    forever begin
      @(negedge Clk);
      cur.stamp = 32'(cyc);
      cur.pl    = '{motor1, motor2, busy, fault, TxValid, TxData};
      checks++;
      if (motor1 && motor2) begin
        errors++;
        $display("FAIL motors_exclusive: got m1=%b m2=%b, need not both high (cyc %0d)", motor1, motor2, cyc);
      end
      if (cur.pl !== seen) begin
        seen = cur.pl;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %s, none expected", fmt(cur));
        end else begin
          e = exp_q.pop_front();
          if (e !== cur) begin
            errors++;
            $display("FAIL output_event: got %s, expected %s", fmt(cur), fmt(e));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit tx_auto = 0;
  bit tx_req  = 0;

  initial begin
    forever begin
      @(negedge Clk);
      TxDone = tx_req || (tx_auto && $urandom_range(0, 3) == 0);
      tx_req = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge Clk);
    RxData = b;
    RxDone = 1'b1;
    @(negedge Clk);
    RxDone = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge Clk);
    #1 Rst_n = 1'b0;
    @(posedge Clk);
    #1 Rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    #2 Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    tx_auto = 1;

    // Reset in the middle of a close, then open from scratch.
    send(8'h43); idle(8);
    pulse_reset();
    send(8'h41); idle(8);

    // Open end-stop pulse while opening; hold the report until a TxDone.
    tx_auto = 0;
    @(negedge Clk); finalcarrera1 = 1'b1;
    idle(3); finalcarrera1 = 1'b0;
    idle(6);
    tx_req = 1; idle(3);
    tx_auto = 1;

    // Reversal through dead-time.
    send(8'h41); idle(7);
    send(8'h43); idle(8);
    send(8'h53); idle(3);

    // Travel timeout, ignored command in fault, then clear.
    send(8'h43); idle(DEAD + TMO + 3);
    send(8'h41); idle(3);
    send(8'h53); idle(3);

    // Both limits while opening; STOP refused while both are held.
    send(8'h41); idle(7);
    @(negedge Clk); finalcarrera1 = 1'b1; finalcarrera2 = 1'b1;
    idle(4);
    send(8'h53); idle(3);
    finalcarrera1 = 1'b0; finalcarrera2 = 1'b0;
    idle(3);
    send(8'h53); idle(3);

    // Two reports before any TxDone: last one wins, one TxDone clears.
    tx_auto = 0;
    tx_req = 1; idle(3);
    finalcarrera1 = 1'b1; idle(3);
    send(8'h41);
    send(8'h53);
    idle(4);
    tx_req = 1; idle(3);
    finalcarrera1 = 1'b0; idle(3);
    tx_auto = 1;

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge Clk);
      if ($urandom_range(0, 39) == 0) finalcarrera1 = ~finalcarrera1;
      if ($urandom_range(0, 59) == 0) finalcarrera2 = ~finalcarrera2;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       b = 8'h41;
          1:       b = 8'h43;
          2:       b = 8'h53;
          default: b = 8'($urandom);
        endcase
        RxData = b;
        RxDone = 1'b1;
      end else begin
        RxDone = 1'b0;
      end
    end
    RxDone = 1'b0;
    finalcarrera1 = 1'b0;
    finalcarrera2 = 1'b0;
    idle(20);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d unseen expected changes, required 0 (next %s)",
               exp_q.size(), fmt(exp_q[0]));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
